// File: rtl/l2_req_sched.sv
// Credit-based request scheduler: FIFO of merged stream requests issued to OpenCAPI while credits remain.
// Optional statistics counters built only when L2_REQ_SCHED_STATS_EN is defined.
module l2_req_sched #(
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int DEPTH        = 16,
  parameter int CREDITS      = 32,
  parameter int CNT_W        = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  input  logic [nstrms_width-1:0] i_req_sid,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [nstrms_width-1:0] o_req_sid,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  input  logic [nstrms_width-1:0] i_rsp_sid,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [nstrms_width-1:0] o_rsp_sid,
  output logic [CNT_W-1:0]        o_outstanding,
  output logic                    o_err,
  output logic [31:0]             o_stat_issued,
  output logic [31:0]             o_stat_stall
);

  // state   | meaning
  // HAVE    | o_outstanding < CREDITS, head of FIFO may issue
  // STARVED | o_outstanding == CREDITS, issue blocked until a response returns
  typedef enum logic {HAVE = 1'b0, STARVED = 1'b1} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t                  state_q, state_d;
  logic [AW:0]             wptr_q, wptr_d;
  logic [AW:0]             rptr_q, rptr_d;
  logic [CNT_W-1:0]        out_q, out_d;
  logic                    err_q, err_d;
  logic [nstrms_width-1:0] mem_q [DEPTH];

  logic full, empty, push, pop, ret;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  // Ready looks only at the registered pointers, so a pop never makes a full FIFO ready this cycle.
  assign i_req_r   = !full;
  assign push      = i_req_v & !full;
  assign o_req_v   = !empty && (state_q == HAVE);
  assign o_req_sid = mem_q[rptr_q[AW-1:0]];
  assign pop       = o_req_v & o_req_r;

  assign o_rsp_v   = i_rsp_v;
  assign o_rsp_sid = i_rsp_sid;
  assign i_rsp_r   = o_rsp_r;
  assign ret       = i_rsp_v & o_rsp_r;

  assign o_outstanding = out_q;
  assign o_err         = err_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    out_d   = out_q;
    err_d   = err_q;

    if (push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};

    if (ret && (out_q == '0)) err_d = 1'b1;

    if (pop && !ret) begin
      out_d = out_q + CNT_W'(1);
    end else if (ret && !pop && (out_q != '0)) begin
      out_d = out_q - CNT_W'(1);
    end

    case (state_q)
      HAVE:    if (pop && !ret && (out_q == CNT_W'(CREDITS - 1))) state_d = STARVED;
      STARVED: if (ret) state_d = HAVE;
      default: state_d = HAVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HAVE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; the pointer reset alone discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= i_req_sid;
  end

`ifdef L2_REQ_SCHED_STATS_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (pop && (issued_q != 32'hFFFF_FFFF)) issued_q <= issued_q + 32'd1;
      if (!empty && (state_q == STARVED) && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stat_issued = issued_q;
  assign o_stat_stall  = stall_q;
`else
  assign o_stat_issued = '0;
  assign o_stat_stall  = '0;
`endif

endmodule

// File: tb/tb_l2_req_sched.sv
// Bench for l2_req_sched: directed test-plan scenarios plus random traffic, checked against a queue model.
// Honours L2_REQ_SCHED_STATS_EN the same way as the design for the statistics outputs.
module tb_l2_req_sched;
  localparam int NSTRMS  = 64;
  localparam int NW      = 6;
  localparam int DEPTH   = 16;
  localparam int CREDITS = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_req_v, i_req_r;
  logic [NW-1:0]    i_req_sid;
  logic             o_req_v, o_req_r;
  logic [NW-1:0]    o_req_sid;
  logic             i_rsp_v, i_rsp_r;
  logic [NW-1:0]    i_rsp_sid;
  logic             o_rsp_v, o_rsp_r;
  logic [NW-1:0]    o_rsp_sid;
  logic [CNT_W-1:0] o_outstanding;
  logic             o_err;
  logic [31:0]      o_stat_issued, o_stat_stall;

  always #5 clk = ~clk;

  l2_req_sched #(
    .nstrms(NSTRMS), .nstrms_width(NW), .DEPTH(DEPTH), .CREDITS(CREDITS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_sid(o_req_sid),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_sid(i_rsp_sid),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid),
    .o_outstanding(o_outstanding), .o_err(o_err),
    .o_stat_issued(o_stat_issued), .o_stat_stall(o_stat_stall)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: queued sids, outstanding count, sticky error, statistics.
  int      mq[$];
  int      m_out   = 0;
  bit      m_err   = 0;
  longint  m_iss   = 0;
  longint  m_stall = 0;
  int      got[$];

  // One clock cycle: drive on the falling edge, compare just after, advance the model.
  task automatic step(input bit rv, input int sid, input bit orr,
                      input bit pv, input int psid, input bit prr, input bit rst_n);
    bit exp_rdy, exp_v, iss, ret;
    @(negedge clk);
    reset     = rst_n;
    i_req_v   = rv;
    i_req_sid = NW'(sid);
    o_req_r   = orr;
    i_rsp_v   = pv;
    i_rsp_sid = NW'(psid);
    o_rsp_r   = prr;
    #1;
    exp_rdy = mq.size() < DEPTH;
    exp_v   = (mq.size() > 0) && (m_out < CREDITS);
    check_eq("i_req_r", i_req_r, exp_rdy);
    check_eq("o_req_v", o_req_v, exp_v);
    if (exp_v) check_eq("o_req_sid", o_req_sid, mq[0]);
    check_eq("o_outstanding", o_outstanding, m_out);
    check_eq("o_err", o_err, m_err);
    check_eq("o_rsp_v", o_rsp_v, pv);
    if (pv) check_eq("o_rsp_sid", o_rsp_sid, psid & (NSTRMS - 1));
    check_eq("i_rsp_r", i_rsp_r, prr);
`ifdef L2_REQ_SCHED_STATS_EN
    check_eq("stat_issued", o_stat_issued, m_iss);
    check_eq("stat_stall", o_stat_stall, m_stall);
`else
    check_eq("stat_issued", o_stat_issued, 0);
    check_eq("stat_stall", o_stat_stall, 0);
`endif
    if (o_req_v && o_req_r) got.push_back(int'(o_req_sid));

    iss = exp_v && orr;
    ret = pv && prr;
    if (!rst_n) begin
      mq.delete();
      m_out = 0; m_err = 0; m_iss = 0; m_stall = 0;
    end else begin
      if ((mq.size() > 0) && (m_out == CREDITS)) m_stall++;
      if (iss) begin m_iss++; void'(mq.pop_front()); end
      if (rv && exp_rdy) mq.push_back(sid & (NSTRMS - 1));
      if (ret && (m_out == 0)) m_err = 1;
      if (iss && !ret) m_out++;
      else if (ret && !iss && (m_out > 0)) m_out--;
    end
  endtask

  task automatic idle(input bit orr);
    step(0, 0, orr, 0, 0, 1, 1);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int next_sid;
    bit acc;
    reset = 0; i_req_v = 0; i_req_sid = '0; o_req_r = 0;
    i_rsp_v = 0; i_rsp_sid = '0; o_rsp_r = 1;
    repeat (3) @(posedge clk);

    // Reset state
    idle(0);
    check_eq("rst_i_req_r", i_req_r, 1);
    check_eq("rst_o_req_v", o_req_v, 0);
    check_eq("rst_outstanding", o_outstanding, 0);
    check_eq("rst_err", o_err, 0);

    // Single request sid 5
    repeat (6) idle(1);
    step(1, 5, 1, 0, 0, 1, 1);
    idle(1);
    check_eq("single_v", o_req_v, 1);
    check_eq("single_sid", o_req_sid, 5);
    idle(1);
    check_eq("single_out1", o_outstanding, 1);
    step(0, 0, 1, 1, 5, 1, 1);
    check_eq("single_rsp_v", o_rsp_v, 1);
    check_eq("single_rsp_sid", o_rsp_sid, 5);
    idle(1);
    check_eq("single_out0", o_outstanding, 0);

    // Credit exhaustion
    do_reset();
    for (int k = 0; k < 6; k++) step(1, k, 1, 0, 0, 1, 1);
    repeat (4) idle(1);
    check_eq("starve_v", o_req_v, 0);
    check_eq("starve_out", o_outstanding, CREDITS);
    step(0, 0, 1, 1, 0, 1, 1);
    check_eq("starve_no_fwd", o_req_v, 0);
    idle(1);
    check_eq("starve_resume_v", o_req_v, 1);
    check_eq("starve_resume_sid", o_req_sid, 4);

    // FIFO full, no pop-through
    do_reset();
    for (int k = 0; k < DEPTH; k++) step(1, k + 20, 0, 0, 0, 1, 1);
    idle(0);
    check_eq("full_rdy0", i_req_r, 0);
    step(1, 63, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 1, 1);
    check_eq("full_pop_rdy", i_req_r, 0);
    check_eq("full_head", o_req_sid, 20);
    idle(0);
    check_eq("full_rdy1", i_req_r, 1);

    // Ordering across pointer wrap
    do_reset();
    got.delete();
    next_sid = 0;
    for (int c = 0; c < 600 && got.size() < 40; c++) begin
      acc = (next_sid < 40) && (mq.size() < DEPTH);
      step(next_sid < 40, next_sid, ($urandom % 4) != 0,
           (m_out > 0) && (($urandom % 2) == 0), 0, 1, 1);
      if (acc) next_sid++;
    end
    check_eq("wrap_count", got.size(), 40);
    for (int k = 0; k < got.size() && k < 40; k++) check_eq("wrap_order", got[k], k);

    // Simultaneous issue and return at 3, then spurious response
    do_reset();
    for (int k = 0; k < 4; k++) step(1, k, 0, 0, 0, 1, 1);
    repeat (3) idle(1);
    step(0, 0, 1, 1, 0, 1, 1);
    check_eq("sim_out_pre", o_outstanding, 3);
    idle(0);
    check_eq("sim_out_post", o_outstanding, 3);
    do_reset();
    step(0, 0, 0, 1, 7, 1, 1);
    idle(0);
    check_eq("spur_err", o_err, 1);
    check_eq("spur_out", o_outstanding, 0);
    idle(0);
    check_eq("spur_sticky", o_err, 1);

    // Reset mid-burst
    do_reset();
    for (int k = 0; k < 10; k++) step(1, k + 30, 0, 0, 0, 1, 1);
    repeat (3) idle(1);
    step(0, 0, 1, 0, 0, 1, 0);
    idle(1);
    check_eq("midrst_v", o_req_v, 0);
    check_eq("midrst_out", o_outstanding, 0);
    repeat (3) idle(1);
    step(1, 9, 1, 0, 0, 1, 1);
    idle(1);
    check_eq("midrst_new_v", o_req_v, 1);
    check_eq("midrst_new_sid", o_req_sid, 9);

    // Statistics
    do_reset();
    for (int k = 0; k < 10; k++) step(1, k, 0, 0, 0, 1, 1);
    repeat (4) idle(1);
    repeat (5) idle(0);
    idle(0);
`ifdef L2_REQ_SCHED_STATS_EN
    check_eq("stat_stall5", o_stat_stall, 5);
    check_eq("stat_issued4", o_stat_issued, 4);
`else
    check_eq("stat_stall_off", o_stat_stall, 0);
    check_eq("stat_issued_off", o_stat_issued, 0);
`endif
    repeat (12) step(0, 0, 1, m_out > 0, 0, 1, 1);
    idle(0);
`ifdef L2_REQ_SCHED_STATS_EN
    check_eq("stat_issued10", o_stat_issued, 10);
`else
    check_eq("stat_issued_off2", o_stat_issued, 0);
`endif

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 3) != 0, $urandom_range(0, NSTRMS - 1), ($urandom % 4) != 0,
           (m_out > 0) ? (($urandom % 2) == 0) : (($urandom % 50) == 0),
           $urandom_range(0, NSTRMS - 1), ($urandom % 5) != 0, ($urandom % 300) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/l2_req_sched.md
# l2_req_sched

Credit-based scheduler between the final L2 request merge and the OpenCAPI 3.0 request port. It buffers merged per-stream cache-line requests in a FIFO and issues them only while transaction credits remain. Credits are returned as OpenCAPI responses are passed back to the L2 response demux. This bounds in-flight reads to what the host interface and the L2 URAM landing space can absorb.

## Interface
- `nstrms`, 64, number of streams; `nstrms_width = $clog2(nstrms)`.
- `DEPTH`, 16, request FIFO entries; power of two, ≥2.
- `CREDITS`, 32, maximum outstanding OpenCAPI requests; 1..255.
- `CNT_W`, `$clog2(CREDITS+1)`, width of the outstanding counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; asserted when 0.
- `i_req_v` in 1: merged request valid.
- `i_req_r` out 1: request accepted when `i_req_v & i_req_r`.
- `i_req_sid` in `nstrms_width`: requesting stream.
- `o_req_v` out 1: request to OpenCAPI valid.
- `o_req_r` in 1: OpenCAPI ready.
- `o_req_sid` out `nstrms_width`: issued stream id.
- `i_rsp_v` in 1: OpenCAPI response valid.
- `i_rsp_r` out 1: response ready.
- `i_rsp_sid` in `nstrms_width`: responding stream.
- `o_rsp_v` out 1: response to L2 demux valid.
- `o_rsp_r` in 1: L2 demux ready.
- `o_rsp_sid` out `nstrms_width`: responding stream.
- `o_outstanding` out `CNT_W`: requests issued and not yet answered.
- `o_err` out 1: sticky, set when a response arrives with zero outstanding.
- `o_stat_issued` out 32: issued-request counter (see Configuration).
- `o_stat_stall` out 32: credit-stall cycle counter (see Configuration).

## Operation
- FIFO uses a circular buffer with `$clog2(DEPTH)+1`-bit read and write pointers. Full means the MSBs differ and the low bits are equal. Empty means the pointers are equal. Pointers wrap naturally.
- Push: `i_req_v & i_req_r`, with `i_req_r = !full`. There is no pop-through when full: a simultaneous pop does not make a full FIFO ready in the same cycle.
- Issue: `o_req_v = !empty & (credits > 0)`, where `credits = CREDITS - o_outstanding`. `o_req_sid` is the head entry. Pop on `o_req_v & o_req_r`.
- The response path is a pure combinational passthrough:
  - `o_rsp_v = i_rsp_v`, `o_rsp_sid = i_rsp_sid`, `i_rsp_r = o_rsp_r`.
  - A credit is returned on `i_rsp_v & i_rsp_r`.
- Outstanding counter:
  - +1 on issue, −1 on a returned response.
  - Issue and return in the same cycle leave it unchanged.
  - A return while at 0 leaves it at 0 and sets `o_err`.
  - The counter never exceeds `CREDITS`.
- Credit state machine, two states:
  - HAVE: `o_outstanding < CREDITS`.
  - STARVED: `o_outstanding == CREDITS`.
  - HAVE→STARVED on an issue at `CREDITS-1` with no return that cycle.
  - STARVED→HAVE on any return.
  - In STARVED, `o_req_v = 0` even when the FIFO is non-empty.
- Reset (including mid-operation) does all of the following:
  - Pointers, `o_outstanding`, `o_err` and stats go to 0. FIFO contents are discarded and the state goes to HAVE.
  - In-flight OpenCAPI transactions are forgotten; late responses then set `o_err`.

## Timing
- Outputs during and after reset: `i_req_r`=1 (first cycle after reset release), `o_req_v`=0, `o_outstanding`=0, `o_err`=0, stats=0. `o_rsp_v` follows `i_rsp_v`.
- Latency from accepted input to `o_req_v`:
  - One cycle, with no bypass.
  - A request pushed in cycle N is presentable in N+1 if credits > 0.
- Throughput: one push and one issue per cycle sustained while not full and not starved.
- A credit returned in cycle N enables issue in N+1. It is not combinationally forwarded to `o_req_v` in cycle N.
- `o_req_v` and `o_req_sid` stay stable while `o_req_r`=0, unless reset is asserted.

## Configuration
- Macro: `L2_REQ_SCHED_STATS_EN`.
- Defined:
  - `o_stat_issued` increments on each issue.
  - `o_stat_stall` increments each cycle with FIFO non-empty and STARVED.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both outputs tie to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Single request: sid 5 pushed at cycle 10 with `o_req_r`=1 → `o_req_v`=1 with sid 5 at cycle 11; `o_outstanding`=1 at cycle 12. Response sid 5 → `o_rsp_v`/sid 5 the same cycle; `o_outstanding`=0 the next cycle.
- Credit exhaustion with `CREDITS`=4 and 6 requests, sids 0..5, no responses:
  - Exactly 4 issued, then `o_req_v`=0 with `o_outstanding`=4.
  - One response, then sid 4 issues the cycle after the response.
- FIFO full with `DEPTH`=16 and `o_req_r`=0: after 16 pushes `i_req_r`=0. One pop → `i_req_r`=1 the next cycle. Order is preserved across pointer wrap (push 40 sequential sids).
- Simultaneous issue and return at `o_outstanding`=3 → stays 3. Spurious response at 0 → `o_err`=1 sticky and the counter stays 0.
- Reset low mid-burst with 7 queued and 3 outstanding → next cycle `o_req_v`=0 and `o_outstanding`=0; no stale sid is issued after release.
- With `L2_REQ_SCHED_STATS_EN`: 10 issues and 5 starved non-empty cycles → `o_stat_issued`=10 and `o_stat_stall`=5. Without the macro, both read 0.
